// File: rtl/sid_rx_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sid_rx_scheduler: parses UART bytes into SID write/delay commands, buffers |
// | them in a FIFO and replays them to the SID bus in SID-clock ticks.         |
// | Optional: define SIDCTL_STATS_EN to add the stat_writes counter port.      |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module sid_rx_scheduler #(
  parameter int FIFO_DEPTH = 16,
  parameter int TICK_DIV   = 32,
  parameter int DELAY_W    = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_valid,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_eop,
  output logic                          sid_we,
  output logic [4:0]                    sid_addr,
  output logic [7:0]                    sid_wdata,
  input  logic                          sid_ack,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          overflow,
  output logic                          frame_err,
`ifdef SIDCTL_STATS_EN
  output logic [15:0]                   stat_writes,
`endif
  input  logic                          clear_err
);

  localparam int c_addrW  = $clog2(FIFO_DEPTH);
  localparam int c_payW   = (DELAY_W > 13) ? DELAY_W : 13;
  localparam int c_entryW = c_payW + 1;
  localparam int c_wideW  = (DELAY_W > 16) ? DELAY_W : 16;
  localparam int c_prescW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {P_CMD, P_DATA, P_DLO, P_DHI} pState_t;
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WAIT} sState_t;

  pState_t r_pState, w_pNext;
  sState_t r_sState, w_sNext;

  logic [4:0]            r_addrLatch;
  logic [7:0]            r_dlo;
  logic                  w_push, w_flush, w_cmdErr, w_eopErr;
  logic [c_entryW-1:0]   w_pushEntry;
  logic [c_wideW-1:0]    w_delayWide;

  logic [c_entryW-1:0]   r_mem [FIFO_DEPTH];
  logic [c_addrW-1:0]    r_rdPtr, r_wrPtr;
  logic [c_addrW:0]      r_count;
  logic                  w_empty, w_full, w_pushOk, w_pop, w_ovfSet;
  logic [c_entryW-1:0]   w_head;
  logic                  w_headIsDelay;
  logic [DELAY_W-1:0]    w_headCount;

  logic                  r_sidWe;
  logic [4:0]            r_sidAddr;
  logic [7:0]            r_sidWdata;
  logic [DELAY_W-1:0]    r_delayCnt;
  logic [c_prescW-1:0]   r_presc;
  logic                  w_tick;
  logic                  r_overflow, r_frameErr;

  // Byte is consumed first; a pending eop then checks the resulting state.
  always_comb begin
    w_pNext     = r_pState;
    w_push      = 1'b0;
    w_flush     = 1'b0;
    w_cmdErr    = 1'b0;
    w_eopErr    = 1'b0;
    w_pushEntry = '0;
    w_delayWide = c_wideW'({rx_data, r_dlo});
    if (rx_valid) begin
      case (r_pState)
        P_CMD: begin
          if (rx_data[7:5] == 3'b000)  w_pNext = P_DATA;
          else if (rx_data == 8'h80)   w_pNext = P_DLO;
          else if (rx_data == 8'hFF)   w_flush = 1'b1;
          else                         w_cmdErr = 1'b1;
        end
        P_DATA: begin
          w_push      = 1'b1;
          w_pushEntry = {1'b0, c_payW'({r_addrLatch, rx_data})};
          w_pNext     = P_CMD;
        end
        P_DLO: w_pNext = P_DHI;
        P_DHI: begin
          w_push      = 1'b1;
          w_pushEntry = {1'b1, c_payW'(w_delayWide[DELAY_W-1:0])};
          w_pNext     = P_CMD;
        end
        default: w_pNext = P_CMD;
      endcase
    end
    if (rx_eop && (w_pNext != P_CMD)) begin
      w_eopErr = 1'b1;
      w_pNext  = P_CMD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pState    <= P_CMD;
      r_addrLatch <= '0;
      r_dlo       <= '0;
    end else begin
      r_pState <= w_pNext;
      if (rx_valid && (r_pState == P_CMD) && (rx_data[7:5] == 3'b000))
        r_addrLatch <= rx_data[4:0];
      if (rx_valid && (r_pState == P_DLO))
        r_dlo <= rx_data;
    end
  end

  assign w_empty       = (r_count == '0);
  assign w_full        = (r_count == (c_addrW+1)'(FIFO_DEPTH));
  assign w_head        = r_mem[r_rdPtr];
  assign w_headIsDelay = w_head[c_payW];
  assign w_headCount   = w_head[DELAY_W-1:0];
  assign w_pushOk      = w_push && !w_flush && (!w_full || w_pop);
  assign w_ovfSet      = w_push && !w_flush && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_pushOk) r_mem[r_wrPtr] <= w_pushEntry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_pushOk) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)    r_rdPtr <= r_rdPtr + 1'b1;
      if (w_pushOk && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_pushOk && w_pop) r_count <= r_count - 1'b1;
    end
  end

  assign w_tick = (r_presc == c_prescW'(TICK_DIV - 1));

  // Pops are held off during a flush so the flushed head is never replayed.
  always_comb begin
    w_sNext = r_sState;
    w_pop   = 1'b0;
    case (r_sState)
      S_IDLE: begin
        if (!w_empty && !w_flush) begin
          w_pop = 1'b1;
          if (!w_headIsDelay)          w_sNext = S_WRITE;
          else if (w_headCount != '0)  w_sNext = S_WAIT;
        end
      end
      S_WRITE: if (r_sidWe && sid_ack) w_sNext = S_IDLE;
      S_WAIT: begin
        if (w_flush) w_sNext = S_IDLE;
        else if (w_tick && (r_delayCnt == DELAY_W'(1))) w_sNext = S_IDLE;
      end
      default: w_sNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sState <= S_IDLE;
    else        r_sState <= w_sNext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sidWe    <= 1'b0;
      r_sidAddr  <= '0;
      r_sidWdata <= '0;
      r_delayCnt <= '0;
      r_presc    <= '0;
    end else begin
      if (w_pop && !w_headIsDelay) begin
        r_sidWe    <= 1'b1;
        r_sidAddr  <= w_head[12:8];
        r_sidWdata <= w_head[7:0];
      end else if (r_sidWe && sid_ack) begin
        r_sidWe <= 1'b0;
      end
      if (w_pop && w_headIsDelay) begin
        r_delayCnt <= w_headCount;
        r_presc    <= '0;
      end else if (r_sState == S_WAIT) begin
        if (w_tick) begin
          r_presc    <= '0;
          r_delayCnt <= r_delayCnt - 1'b1;
        end else begin
          r_presc <= r_presc + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
      r_frameErr <= 1'b0;
    end else begin
      if (w_ovfSet)       r_overflow <= 1'b1;
      else if (clear_err) r_overflow <= 1'b0;
      if (w_cmdErr || w_eopErr) r_frameErr <= 1'b1;
      else if (clear_err)       r_frameErr <= 1'b0;
    end
  end

`ifdef SIDCTL_STATS_EN
  logic [15:0] r_statWrites;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r_statWrites <= '0;
    else if (r_sidWe && sid_ack)  r_statWrites <= r_statWrites + 1'b1;
  end
  assign stat_writes = r_statWrites;
`endif

  assign sid_we     = r_sidWe;
  assign sid_addr   = r_sidAddr;
  assign sid_wdata  = r_sidWdata;
  assign fifo_level = r_count;
  assign busy       = !w_empty || (r_sState != S_IDLE);
  assign overflow   = r_overflow;
  assign frame_err  = r_frameErr;

endmodule
`default_nettype wire

// File: tb/tb_sid_rx_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sid_rx_scheduler: directed vectors with a write scoreboard/monitor.     |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_sid_rx_scheduler;

  localparam int c_depth = 4;
  localparam int c_tick  = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_eop = 1'b0;
  logic        sid_ack = 1'b0;
  logic        clear_err = 1'b0;
  logic        sid_we;
  logic [4:0]  sid_addr;
  logic [7:0]  sid_wdata;
  logic [$clog2(c_depth):0] fifo_level;
  logic        busy, overflow, frame_err;
`ifdef SIDCTL_STATS_EN
  logic [15:0] stat_writes;
`endif

  sid_rx_scheduler #(.FIFO_DEPTH(c_depth), .TICK_DIV(c_tick), .DELAY_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .rx_eop(rx_eop),
    .sid_we(sid_we), .sid_addr(sid_addr), .sid_wdata(sid_wdata), .sid_ack(sid_ack),
    .fifo_level(fifo_level), .busy(busy), .overflow(overflow), .frame_err(frame_err),
`ifdef SIDCTL_STATS_EN
    .stat_writes(stat_writes),
`endif
    .clear_err(clear_err)
  );

  always #5 clk = ~clk;

  int nVec = 0;
  int nFail = 0;
  int expWrites = 0;
  logic [12:0] expQ[$];

  task automatic check(input string name, input int act, input int exp);
    nVec++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expectWrite(input logic [4:0] a, input logic [7:0] d);
    expQ.push_back({a, d});
    expWrites++;
  endtask

  task automatic sendByte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic sendEop();
    rx_eop = 1'b1;
    @(posedge clk);
    #1 rx_eop = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while (busy && n < 500) begin
      @(posedge clk);
      #1 n++;
    end
    check(name, int'(busy), 0);
  endtask

  // Scoreboard monitor: every completed handshake must match the queue head.
  always @(negedge clk) begin
    if (rst_n && sid_we && sid_ack) begin
      nVec++;
      if (expQ.size() == 0) begin
        nFail++;
        $display("FAIL write_unexpected: got addr 0x%0h data 0x%0h, expected none", sid_addr, sid_wdata);
      end else begin
        logic [12:0] e;
        e = expQ.pop_front();
        if ({sid_addr, sid_wdata} != e) begin
          nFail++;
          $display("FAIL write_order: got addr 0x%0h data 0x%0h, expected addr 0x%0h data 0x%0h",
                   sid_addr, sid_wdata, e[12:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sid_we", int'(sid_we), 0);
    check("rst_fifo_level", int'(fifo_level), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_frame_err", int'(frame_err), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single write with ack tied high
    sid_ack = 1'b1;
    expectWrite(5'h18, 8'h0F);
    sendByte(8'h18);
    sendByte(8'h0F);
    waitIdle("t1_idle");
    check("t1_level", int'(fifo_level), 0);
    check("t1_frame_err", int'(frame_err), 0);
    check("t1_overflow", int'(overflow), 0);

    // Delay of 3 ticks then a write: strobe 98 cycles after the DHI byte
    expectWrite(5'h01, 8'hAA);
    sendByte(8'h80);
    sendByte(8'h03);
    sendByte(8'h00);
    sendByte(8'h01);
    sendByte(8'hAA);
    cycles = 2;
    while (!sid_we && cycles < 300) begin
      @(posedge clk);
      #1 cycles++;
      if (cycles == 50) begin
        check("t2_mid_level", int'(fifo_level), 1);
        check("t2_mid_busy", int'(busy), 1);
      end
    end
    check("t2_strobe_latency", cycles, 98);
    waitIdle("t2_idle");

    // Truncated frame, then a good write, then clear
    sendByte(8'h01);
    sendEop();
    check("t3_frame_err_set", int'(frame_err), 1);
    expectWrite(5'h02, 8'h55);
    sendByte(8'h02);
    sendByte(8'h55);
    waitIdle("t3_idle");
    clear_err = 1'b1;
    @(posedge clk);
    #1 clear_err = 1'b0;
    check("t3_frame_err_clr", int'(frame_err), 0);
    sendEop();
    check("t3_eop_in_cmd", int'(frame_err), 0);

    // Byte and eop together completing a frame is not an error
    expectWrite(5'h09, 8'h77);
    sendByte(8'h09);
    rx_eop = 1'b1;
    sendByte(8'h77);
    rx_eop = 1'b0;
    waitIdle("t3b_idle");
    check("t3b_no_err", int'(frame_err), 0);

    // Overflow with ack held low
    sid_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) expectWrite(5'(8'h10 + i), 8'(8'hA0 + i));
      sendByte(8'(8'h10 + i));
      sendByte(8'(8'hA0 + i));
    end
    @(posedge clk);
    #1;
    check("t4_overflow", int'(overflow), 1);
    check("t4_level", int'(fifo_level), 4);
    check("t4_we_held", int'(sid_we), 1);
    check("t4_addr_held", int'(sid_addr), 8'h10);
    check("t4_data_held", int'(sid_wdata), 8'hA0);
    sid_ack = 1'b1;
    waitIdle("t4_idle");
    check("t4_drained", expQ.size(), 0);
    clear_err = 1'b1;
    @(posedge clk);
    #1 clear_err = 1'b0;
    check("t4_overflow_clr", int'(overflow), 0);

    // Long delay plus queued write, aborted by flush
    sendByte(8'h80);
    sendByte(8'hFF);
    sendByte(8'hFF);
    sendByte(8'h03);
    sendByte(8'h33);
    repeat (5) @(posedge clk);
    #1;
    check("t5_busy_wait", int'(busy), 1);
    check("t5_level_pre", int'(fifo_level), 1);
    sendByte(8'hFF);
    check("t5_busy_flush", int'(busy), 0);
    check("t5_level_flush", int'(fifo_level), 0);
    repeat (20) @(posedge clk);
    #1;
    check("t5_still_idle", int'(busy), 0);

    // Bad command byte; parser must still accept a following write
    sendByte(8'h40);
    check("t6_frame_err", int'(frame_err), 1);
`ifdef SIDCTL_STATS_EN
    check("t6_stats_hold", int'(stat_writes), expWrites);
`endif
    expectWrite(5'h05, 8'h66);
    sendByte(8'h05);
    sendByte(8'h66);
    waitIdle("t6_idle");
`ifdef SIDCTL_STATS_EN
    check("t6_stats_inc", int'(stat_writes), expWrites);
`endif

    // Set wins over clear in the same cycle
    clear_err = 1'b1;
    sendByte(8'h41);
    clear_err = 1'b0;
    check("t7_set_wins", int'(frame_err), 1);

    check("final_queue_empty", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
`default_nettype wire
